am_align_ctrl_rx: RTL
=====================

Name: am_align_ctrl_rx

Overview:
- Per-PCS RX alignment controller for the LANE_N instances of am_lock_rx.
- Monitors each lane's block lock and its detected logical lane.
- Asserts align_status once every physical lane is locked and the lane map is a valid permutation.
- Restarts individual lane lockers on timeout, and all lane lockers on map errors; publishes the physical-to-logical lane map to the downstream deskew/reorder stage.

Parameters:
- LANE_N, 4, number of physical lanes; each lane_i entry is LANE_N bits one-hot.
- LANE_W, $clog2(LANE_N), width of one encoded logical lane index.
- TIMEOUT_N, 65536, cycles allowed in WAIT_LOCK before restarting unlocked lanes (covers more than 3 AM gaps of 16384 blocks).
- TIMEOUT_W, $clog2(TIMEOUT_N), timer width.
- RESTART_CYC, 4, cycles lock_nreset_o is held low during RESTART.

Ports:
- clk  in  1  block clock.
- nreset  in  1  asynchronous active-low reset.
- lock_v_i  in  LANE_N  lock_v_o of each physical lane's am_lock_rx.
- lane_i  in  LANE_N*LANE_N  lane_o of each physical lane; physical lane p occupies bits [p*LANE_N +: LANE_N].
- lock_nreset_o  out  LANE_N  per-lane active-low restart to each am_lock_rx nreset.
- align_status_o  out  1  all lanes locked and map valid.
- lane_map_o  out  LANE_N*LANE_W  logical index of physical lane p at [p*LANE_W +: LANE_W].

Behaviour:
- Reset values (async, nreset=0):
  - state=INIT, align_status_o=0, lane_map_o=0.
  - lock_nreset_o=all 0: lockers are held in reset.
  - timer=0, restart counter=0, restart mask=0.
- INIT: unconditional for 1 cycle; lock_nreset_o becomes all 1 on exit; next state WAIT_LOCK with timer=0.
- WAIT_LOCK:
  - timer increments each cycle.
  - If lock_v_i is all ones -> CHECK_MAP. This has priority over timeout in the same cycle.
  - Else if timer==TIMEOUT_N-1 -> RESTART with mask=~lock_v_i; only unlocked lanes are restarted.
- CHECK_MAP: 1 cycle; compares against lane_i sampled in that cycle.
  - Pass requires every lane_i entry to be exactly one-hot and the OR of all entries to be all ones.
  - Pass -> ALIGNED; register lane_map_o with the one-hot-to-binary encoding of each entry; align_status_o=1 on the same edge.
  - Fail -> RESTART with mask=all ones.
  - If any lock_v_i has dropped -> WAIT_LOCK, timer=0; this has priority over the pass/fail result.
- ALIGNED:
  - align_status_o stays 1.
  - Any lock_v_i=0 -> WAIT_LOCK, timer=0; align_status_o=0 and lane_map_o=0 on that edge.
  - Otherwise, any lane_i entry differing from the captured map -> RESTART with mask=all ones; align_status_o=0 and lane_map_o=0.
  - Lock loss takes priority over map change in the same cycle.
- RESTART:
  - lock_nreset_o[p]=~mask[p] for exactly RESTART_CYC cycles; lanes not in the mask stay 1.
  - Then -> WAIT_LOCK with lock_nreset_o=all 1 and timer=0.
  - lock_v_i is ignored while in RESTART.
- Latency: align_status_o rises 2 edges after the first cycle in WAIT_LOCK with all lanes locked. It falls 1 edge after lock loss or map change in ALIGNED.
- Mid-operation reset: immediate return to reset values from any state; restart counter and timer are cleared.
- All outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro: AM_ALIGN_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt_o, 8 bits, reset 0.
  - Counts entries into RESTART from CHECK_MAP fail, ALIGNED map change, or timeout.
  - Saturates at 8'hff.
  - Adds output map_err_o, 1 bit, pulsed for 1 cycle on CHECK_MAP fail.
- Undefined: neither port nor the counter logic exists; behaviour is otherwise identical.

Test Plan:
- Clean alignment: TIMEOUT_N=100; after reset raise lock_v_i=4'hf with lane_i identity, one-hot 1,2,4,8 on lanes 0..3 -> align_status_o=1 two edges later; lane_map_o=8'he4.
- Swapped lanes: lane_i entries 2,1,8,4 -> align_status_o=1; lane_map_o=8'hb1 (1,0,3,2).
- Duplicate map: lane_i entries 1,1,4,8 with all locked -> enter RESTART; lock_nreset_o=4'h0 for exactly 4 cycles, then 4'hf; align_status_o stays 0; err_cnt_o=1 when macro defined.
- Timeout: TIMEOUT_N=100, lock_v_i=4'b1011 held -> at cycle 100 of WAIT_LOCK, lock_nreset_o=4'b1011 for 4 cycles, then all 1; timer restarts.
- Lock loss when aligned: drop lock_v_i[1] -> align_status_o=0 and lane_map_o=0 next edge, no restart pulse. Restore lock -> realigns after 2 edges.
- Priority and reset: same cycle lock_v_i[0] drop and lane_i[3] change while ALIGNED -> WAIT_LOCK, no restart. Assert nreset=0 during RESTART -> lock_nreset_o=0 and align_status_o=0 immediately; INIT on release.

Source files
------------

// File: rtl/am_align_ctrl_rx.sv
// am_align_ctrl_rx: per-PCS RX alignment controller; checks lane locks and lane map, restarts lockers.
// Optional AM_ALIGN_ERR_CNT_EN adds err_cnt_o and map_err_o.
module am_align_ctrl_rx #(
  parameter int LANE_N      = 4,
  parameter int LANE_W      = $clog2(LANE_N),
  parameter int TIMEOUT_N   = 65536,
  parameter int TIMEOUT_W   = $clog2(TIMEOUT_N),
  parameter int RESTART_CYC = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [LANE_N-1:0]          lock_v_i,
  input  logic [LANE_N*LANE_N-1:0]   lane_i,
  output logic [LANE_N-1:0]          lock_nreset_o,
  output logic                       align_status_o,
  output logic [LANE_N*LANE_W-1:0]   lane_map_o
`ifdef AM_ALIGN_ERR_CNT_EN
  ,
  output logic [7:0]                 err_cnt_o,
  output logic                       map_err_o
`endif
);
  localparam int RC_W = $clog2(RESTART_CYC + 1);
  typedef enum logic [2:0] {INIT, WAIT_LOCK, CHECK_MAP, ALIGNED, RESTART} state_t;
  state_t state_q, state_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [LANE_N-1:0] nrst_q, nrst_d, or_all;
  logic align_q, align_d, map_ok, map_chg, all_lock;
  logic [LANE_N*LANE_W-1:0] map_q, map_d, enc;
  assign all_lock = &lock_v_i;
  always_comb begin
    enc = '0;
    or_all = '0;
    map_ok = 1'b1;
    map_chg = 1'b0;
    for (int p = 0; p < LANE_N; p++) begin
      map_ok = map_ok & $onehot(lane_i[p*LANE_N +: LANE_N]);
      or_all = or_all | lane_i[p*LANE_N +: LANE_N];
      for (int l = 0; l < LANE_N; l++)
        if (lane_i[p*LANE_N+l]) enc[p*LANE_W +: LANE_W] = LANE_W'(l);
      map_chg = map_chg | (lane_i[p*LANE_N +: LANE_N] != (LANE_N'(1) << map_q[p*LANE_W +: LANE_W]));
    end
    map_ok = map_ok & (&or_all);
  end
  // lock_nreset_o is held at ~mask for the whole RESTART stay, so the mask needs no own register
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rcnt_d = '0;
    nrst_d = nrst_q;
    align_d = align_q;
    map_d = map_q;
    case (state_q)
      INIT: begin
        state_d = WAIT_LOCK;
        nrst_d = '1;
        timer_d = '0;
      end
      WAIT_LOCK: begin
        timer_d = timer_q + 1'b1;
        if (all_lock) state_d = CHECK_MAP;
        else if (timer_q == TIMEOUT_W'(TIMEOUT_N - 1)) begin
          state_d = RESTART;
          nrst_d = lock_v_i;
        end
      end
      CHECK_MAP:
        if (!all_lock) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (map_ok) begin
          state_d = ALIGNED;
          align_d = 1'b1;
          map_d = enc;
        end else begin
          state_d = RESTART;
          nrst_d = '0;
        end
      ALIGNED:
        if (!all_lock) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          align_d = 1'b0;
          map_d = '0;
        end else if (map_chg) begin
          state_d = RESTART;
          nrst_d = '0;
          align_d = 1'b0;
          map_d = '0;
        end
      RESTART: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == RC_W'(RESTART_CYC - 1)) begin
          state_d = WAIT_LOCK;
          nrst_d = '1;
          timer_d = '0;
          rcnt_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= INIT;
      timer_q <= '0;
      rcnt_q <= '0;
      nrst_q <= '0;
      align_q <= 1'b0;
      map_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rcnt_q <= rcnt_d;
      nrst_q <= nrst_d;
      align_q <= align_d;
      map_q <= map_d;
    end
  assign lock_nreset_o = nrst_q;
  assign align_status_o = align_q;
  assign lane_map_o = map_q;
`ifdef AM_ALIGN_ERR_CNT_EN
  logic [7:0] err_q;
  logic merr_q;
  // every way into RESTART is an error: timeout, map check fail, or map change
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      err_q <= '0;
      merr_q <= 1'b0;
    end else begin
      merr_q <= state_q == CHECK_MAP && state_d == RESTART;
      if (state_q != RESTART && state_d == RESTART && err_q != 8'hff) err_q <= err_q + 1'b1;
    end
  assign err_cnt_o = err_q;
  assign map_err_o = merr_q;
`endif
endmodule
